// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and the byte-lane helpers used by the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    store_be = 4'b0001 << off;
      F3_H:    store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate narrow data across all lanes so the byte enables alone pick the target.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B:    store_lanes = {4{wd[7:0]}};
      F3_H:    store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] dout);
    logic [31:0] sh;
    sh = dout >> {off, 3'b000};
    case (f3)
      F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   load_extend = {24'h0, sh[7:0]};
      F3_HU:   load_extend = {16'h0, sh[15:0]};
      default: load_extend = dout;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed data RAM: 4 byte lanes with per-lane write enable and a
// registered read port that only updates when re is high.
module dmem_bank #(
  parameter int DEPTH_LOG2 = 14,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: decode and error checks, single response register,
// synchronous-read RAM bank and load extension mux.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH_LOG2 = 14,
  parameter logic [XLEN-1:0] BASE_ADDR  = '0,
  parameter                  INIT_FILE  = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int HI = DEPTH_LOG2 + 2;

  logic [1:0]            off;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  in_range, err, accept;
  logic                  ram_re;
  logic [3:0]            ram_we;
  logic [31:0]           ram_dout;

  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q, rsp_err_d;
  logic       ld_q, ld_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;

  assign off      = req_addr[1:0];
  assign widx     = req_addr[HI-1:2];
  assign in_range = req_addr[XLEN-1:HI] == BASE_ADDR[XLEN-1:HI];

  always_comb begin
    err = ~in_range;
    case (req_funct3)
      F3_B:    ;
      F3_H:    err |= off[0];
      F3_W:    err |= (off != 2'b00);
      F3_BU:   err |= req_we;
      F3_HU:   err |= req_we | off[0];
      default: err = 1'b1;
    endcase
  end

  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready & ~flush;
  // RAM is touched only on accept, so dout stays put while a response stalls.
  assign ram_re    = accept & ~req_we & ~err;
  assign ram_we    = {4{accept & req_we & ~err}} & store_be(req_funct3, off);

  dmem_bank #(.DEPTH_LOG2(DEPTH_LOG2), .INIT_FILE(INIT_FILE)) u_bank (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (widx),
    .wdata (store_lanes(req_funct3, req_wdata)),
    .rdata (ram_dout)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    ld_d        = ld_q;
    f3_d        = f3_q;
    off_d       = off_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      ld_d        = ~req_we & ~err;
      f3_d        = req_funct3;
      off_d       = off;
    end else if (flush | rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ld_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      ld_q        <= ld_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q & rsp_err_q;
  assign rsp_rdata = (rsp_valid_q & ld_q) ? load_extend(f3_q, off_q, ram_dout) : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a byte-level memory model predicts each response,
// a monitor compares whatever the DUT presents against the queue head.
module tb_mem_lsu;

  localparam int          DL    = 14;
  localparam logic [31:0] LIMIT = 32'h0001_0000;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(32), .DEPTH_LOG2(DL), .BASE_ADDR(32'h0), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  exp_t       q[$];
  logic [7:0] mm [logic [31:0]];
  int         cyc = 0, n_chk = 0, n_pass = 0;
  bit         head_seen = 0, rnd_on = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rnd_on) rsp_ready <= ($urandom_range(3) != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    return (a >= LIMIT) || f3 == 3 || f3 == 6 || f3 == 7 ||
           ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 0) ||
           (we && (f3 == 4 || f3 == 5));
  endfunction

  function automatic logic [31:0] m_rd(input bit we, input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    if (we || m_err(we, f3, a)) return 32'h0;
    b0 = mm[a];
    b1 = (f3 == 0 || f3 == 4) ? 8'h0 : mm[a + 1];
    b2 = (f3 == 2) ? mm[a + 2] : 8'h0;
    b3 = (f3 == 2) ? mm[a + 3] : 8'h0;
    case (f3)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd4:    return {24'h0, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd5:    return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic void m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    if (m_err(1'b1, f3, a)) return;
    n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    for (int i = 0; i < n; i++) mm[a + i] = wd[8*i +: 8];
  endfunction

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int waits);
    exp_t e;
    bit   done = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    waits = 0;
    while (!done) begin
      @(negedge clk);
      if (req_ready && !flush) begin
        e.err = m_err(we, f3, a); e.rdata = m_rd(we, f3, a); e.cyc = cyc + 1;
        q.push_back(e);
        if (we) m_store(f3, a, wd);
        done = 1;
      end else if (++waits > 50) begin
        check("issue_timeout", waits, 0);
        done = 1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("drain_empty", q.size(), 0);
  endtask

  // Monitor: every presented response must match the queue head and stay stable.
  always @(negedge clk) if (rst_n) begin
    if (rsp_valid) begin
      if (q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        if (!head_seen) begin check("latency", cyc, q[0].cyc); head_seen = 1; end
        check("rsp_err", rsp_err, q[0].err);
        check("rsp_rdata", rsp_rdata, q[0].rdata);
        if (flush || rsp_ready) begin void'(q.pop_front()); head_seen = 0; end
      end
    end
    check("req_ready", req_ready, !rsp_valid || rsp_ready);
  end

  initial begin
    int w;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    #12;
    check("reset_valid", rsp_valid, 0);
    check("reset_err", rsp_err, 0);
    check("reset_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1, 3'd2, 32'h0000, 32'h1234_5678, w);
    issue(1, 3'd2, 32'h0100, 32'hDEAD_BEEF, w);
    issue(0, 3'd2, 32'h0100, 32'h0, w);
    issue(1, 3'd2, 32'h0200, 32'h0, w);
    issue(1, 3'd0, 32'h0203, 32'h0000_0080, w);
    issue(0, 3'd0, 32'h0203, 32'h0, w);
    issue(0, 3'd4, 32'h0203, 32'h0, w);
    issue(0, 3'd2, 32'h0200, 32'h0, w);
    issue(1, 3'd1, 32'h0101, 32'h0000_5555, w);
    issue(0, 3'd2, 32'h0100, 32'h0, w);
    issue(0, 3'd2, 32'h0102, 32'h0, w);
    issue(0, 3'd3, 32'h0100, 32'h0, w);
    issue(1, 3'd4, 32'h0100, 32'hFF, w);
    issue(0, 3'd1, 32'h0102, 32'h0, w);
    issue(0, 3'd5, 32'h0102, 32'h0, w);
    issue(1, 3'd2, LIMIT, 32'hCAFE_F00D, w);
    issue(0, 3'd2, LIMIT, 32'h0, w);
    issue(0, 3'd2, 32'h0000, 32'h0, w);
    issue(1, 3'd2, LIMIT - 4, 32'hA5A5_1234, w);
    issue(0, 3'd2, LIMIT - 4, 32'h0, w);
    drain();

    // Stall with a request waiting, then release.
    rsp_ready = 1'b0;
    issue(0, 3'd2, 32'h0100, 32'h0, w);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0200;
    repeat (3) begin
      @(negedge clk); check("stall_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    issue(0, 3'd2, 32'h0200, 32'h0, w);
    check("release_accept_waits", w, 0);
    drain();

    // Flush a pending load while a new request is offered.
    rsp_ready = 1'b0;
    issue(0, 3'd2, 32'h0100, 32'h0, w);
    flush = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = LIMIT - 4;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk); check("flush_valid", rsp_valid, 0);
    @(posedge clk); #1;

    // Async reset with a response pending.
    rsp_ready = 1'b0;
    issue(0, 3'd0, 32'h0203, 32'h0, w);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", rsp_valid, 0);
    check("midreset_err", rsp_err, 0);
    check("midreset_rdata", rsp_rdata, 0);
    q.delete(); head_seen = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) issue(1, 3'd2, 32'h0400 + 4*i, $urandom, w);
    rnd_on = 1;
    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(7));
      r  = $urandom_range(19);
      a  = (r == 0) ? LIMIT + $urandom_range(255) :
           (r == 1) ? LIMIT - 4 + $urandom_range(3) : 32'h0400 + $urandom_range(63);
      issue(1'($urandom_range(1)), f3, a, $urandom, w);
    end
    rnd_on = 0;
    rsp_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
